serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock,
// with a single full-subtractor cell and a registered borrow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] r_sr_q, r_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic x, y, d_bit, br_nx;

  // Full-subtractor cell on the current operand LSBs
  always_comb begin
    x     = a_sr_q[0];
    y     = b_sr_q[0];
    d_bit = x ^ y ^ br_q;
    br_nx = (~x & y) | (~(x ^ y) & br_q);
  end

  // Next-state and datapath updates; results move only on the last bit
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    r_sr_d   = r_sr_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          r_sr_d  = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        r_sr_d = {d_bit, r_sr_q[WIDTH-1:1]};
        br_d   = br_nx;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = {d_bit, r_sr_q[WIDTH-1:1]};
          borrow_d = br_nx;
          ovf_d    = (amsb_q ^ bmsb_q) & (d_bit ^ amsb_q);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      r_sr_q   <= r_sr_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == BUSY);
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Expected values are hand-computed constants.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] last_diff = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done after acceptance; checks busy and held diff meanwhile
  task automatic wait_done(input string tag, output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (done !== 1'b1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_hold"}, 32'(diff), 32'(last_diff));
      end
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [W-1:0] av,
                        input logic [W-1:0] bv,
                        input logic [W-1:0] ed,
                        input logic eb,
                        input logic eo);
    int n;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = ~av;
    b = ~bv;
    chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
    chk({tag, "_acc_done"}, 32'(done), 32'd0);
    wait_done(tag, n);
    chk({tag, "_lat"},    32'(n),      32'd8);
    chk({tag, "_diff"},   32'(diff),   32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    chk({tag, "_ovf"},    32'(ovf),    32'(eo));
    chk({tag, "_idle"},   32'(busy),   32'd0);
    last_diff = ed;
    tick();
    chk({tag, "_drop"},   32'(done),   32'd0);
    chk({tag, "_keep"},   32'(diff),   32'(ed));
  endtask

  initial begin
    int n;
    int seen;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_diff",   32'(diff),   32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    chk("rst_ovf",    32'(ovf),    32'd0);
    rst_n = 1'b1;
    tick();

    run_op("s100_37", 8'd100, 8'd37, 8'h3F, 1'b0, 1'b0);
    run_op("s00_01",  8'h00,  8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("sA5_A5",  8'hA5,  8'hA5, 8'h00, 1'b0, 1'b0);
    run_op("s80_01",  8'h80,  8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("s7F_FF",  8'h7F,  8'hFF, 8'h80, 1'b1, 1'b1);

    a = 8'h10;
    b = 8'h03;
    start = 1'b1;
    tick();
    for (int i = 1; i < 8; i++) begin
      a = 8'(i * 37);
      b = 8'(i * 91);
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_nodone", 32'(done), 32'd0);
      tick();
    end
    a = 8'd5;
    b = 8'd3;
    tick();
    chk("b2b_done1", 32'(done),   32'd1);
    chk("b2b_diff1", 32'(diff),   32'h0D);
    chk("b2b_br1",   32'(borrow), 32'd0);
    chk("b2b_ovf1",  32'(ovf),    32'd0);
    chk("b2b_idle1", 32'(busy),   32'd0);
    last_diff = 8'h0D;
    tick();
    start = 1'b0;
    a = 8'hEE;
    b = 8'h77;
    chk("b2b_acc_busy", 32'(busy), 32'd1);
    chk("b2b_acc_done", 32'(done), 32'd0);
    wait_done("b2b2", n);
    chk("b2b_lat2",  32'(n),      32'd8);
    chk("b2b_diff2", 32'(diff),   32'd2);
    chk("b2b_br2",   32'(borrow), 32'd0);
    chk("b2b_ovf2",  32'(ovf),    32'd0);
    last_diff = 8'd2;
    tick();

    a = 8'd200;
    b = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("abt_busy",   32'(busy),   32'd0);
    chk("abt_done",   32'(done),   32'd0);
    chk("abt_diff",   32'(diff),   32'd0);
    chk("abt_borrow", 32'(borrow), 32'd0);
    chk("abt_ovf",    32'(ovf),    32'd0);
    rst_n = 1'b1;
    last_diff = '0;
    seen = 0;
    repeat (12) begin
      tick();
      if (done === 1'b1) seen++;
    end
    chk("abt_nodone", 32'(seen), 32'd0);
    chk("abt_diff_z", 32'(diff), 32'd0);

    run_op("s200_10", 8'd200, 8'd10, 8'd190, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
